// File: rtl/bidir_pad_ctrl.sv
// Serial-programmed per-pad control register file for the bidirectional pad ring.
// A host SPI mode-0 link, oversampled in the clk domain, writes pad controls and reads pad state.
module bidir_pad_ctrl #(
  parameter int unsigned NUM_BIDIR = 42
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_csn,
  input  logic                 cfg_sck,
  input  logic                 cfg_mosi,
  output logic                 cfg_miso,
  output logic                 cfg_miso_oe,
  input  logic [NUM_BIDIR-1:0] bidir_in,
  output logic [NUM_BIDIR-1:0] bidir_out,
  output logic [NUM_BIDIR-1:0] bidir_oe,
  output logic [NUM_BIDIR-1:0] bidir_cs,
  output logic [NUM_BIDIR-1:0] bidir_sl,
  output logic [NUM_BIDIR-1:0] bidir_ie,
  output logic [NUM_BIDIR-1:0] bidir_pu,
  output logic [NUM_BIDIR-1:0] bidir_pd,
  output logic                 frame_done,
  output logic                 frame_err
);

  // {oe, out, cs, sl, ie, pu, pd}
  localparam logic [6:0] CfgReset = 7'b000_0101;

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  state_e         state_q;
  logic [2:0]     csn_sync_q;
  logic [2:0]     sck_sync_q;
  logic [1:0]     mosi_sync_q;
  logic [4:0]     bit_cnt_q;
  logic [15:0]    shift_in_q;
  logic [15:0]    shift_out_q;
  logic [15:0]    resp_q;
  logic           resp_pend_q;
  logic           miso_oe_q;
  logic           done_q;
  logic           err_q;
  logic [6:0]     cfg_q [NUM_BIDIR];
  logic [NUM_BIDIR-1:0] pd_q;

  logic           csn_fall, csn_rise, sck_rise, sck_fall;
  logic [5:0]     idx;
  logic           rd_hit;
  logic           rd_in;
  logic [6:0]     rd_cfg;
  logic [15:0]    resp_word;

  // Index [1] is the synchronised value, [2] the delayed copy for edge detection.
  assign csn_fall = csn_sync_q[2] & ~csn_sync_q[1];
  assign csn_rise = ~csn_sync_q[2] & csn_sync_q[1];
  assign sck_rise = ~sck_sync_q[2] & sck_sync_q[1];
  assign sck_fall = sck_sync_q[2] & ~sck_sync_q[1];
  assign idx      = shift_in_q[14:9];

  always_comb begin
    rd_hit = 1'b0;
    rd_in  = 1'b0;
    rd_cfg = 7'h00;
    for (int i = 0; i < NUM_BIDIR; i++) begin
      if (idx == 6'(i)) begin
        rd_hit = 1'b1;
        rd_in  = bidir_in[i];
        rd_cfg = cfg_q[i];
      end
    end
    resp_word = rd_hit ? {1'b1, rd_in, idx, 1'b0, rd_cfg} : {2'b00, idx, 8'h00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csn_sync_q  <= 3'b111;
      sck_sync_q  <= 3'b000;
      mosi_sync_q <= 2'b00;
    end else begin
      csn_sync_q  <= {csn_sync_q[1:0], cfg_csn};
      sck_sync_q  <= {sck_sync_q[1:0], cfg_sck};
      mosi_sync_q <= {mosi_sync_q[0], cfg_mosi};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 5'd0;
      shift_in_q  <= 16'h0000;
      shift_out_q <= 16'h0000;
      resp_q      <= 16'h0000;
      resp_pend_q <= 1'b0;
      miso_oe_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pd_q        <= '1;
      for (int i = 0; i < NUM_BIDIR; i++) begin
        cfg_q[i] <= CfgReset;
      end
    end else begin
      miso_oe_q <= ~csn_sync_q[1];
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (csn_fall) begin
            state_q     <= StShift;
            bit_cnt_q   <= 5'd0;
            shift_out_q <= resp_pend_q ? resp_q : 16'h0000;
            resp_pend_q <= 1'b0;
          end
        end
        StShift: begin
          if (csn_rise) begin
            state_q <= StCommit;
            if (bit_cnt_q == 5'd16) begin
              done_q <= 1'b1;
              if (shift_in_q[15]) begin
                // A write outside the pad range matches no entry and is dropped.
                for (int i = 0; i < NUM_BIDIR; i++) begin
                  if (idx == 6'(i)) begin
                    cfg_q[i] <= shift_in_q[6:0];
                    pd_q[i]  <= shift_in_q[0] & ~shift_in_q[1];
                  end
                end
              end else begin
                resp_q      <= resp_word;
                resp_pend_q <= 1'b1;
              end
            end else if (bit_cnt_q != 5'd0) begin
              err_q <= 1'b1;
            end
          end else begin
            if (sck_rise) begin
              shift_in_q <= {shift_in_q[14:0], mosi_sync_q[1]};
              if (bit_cnt_q != 5'd17) begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
            if (sck_fall) begin
              shift_out_q <= {shift_out_q[14:0], 1'b0};
            end
          end
        end
        StCommit: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BIDIR; i++) begin
      bidir_oe[i]  = cfg_q[i][6];
      bidir_out[i] = cfg_q[i][5];
      bidir_cs[i]  = cfg_q[i][4];
      bidir_sl[i]  = cfg_q[i][3];
      bidir_ie[i]  = cfg_q[i][2];
      bidir_pu[i]  = cfg_q[i][1];
    end
  end

  assign bidir_pd    = pd_q;
  assign cfg_miso    = shift_out_q[15];
  assign cfg_miso_oe = miso_oe_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_bidir_pad_ctrl.sv
// Directed bench for bidir_pad_ctrl: SPI frames driven from one initial block,
// each result checked with an immediate assertion against hand-computed values.
module tb_bidir_pad_ctrl;

  localparam int N = 42;
  localparam logic [N-1:0] All1 = {N{1'b1}};
  localparam logic [N-1:0] Bit5 = 42'd1 << 5;
  localparam logic [N-1:0] Bit9 = 42'd1 << 9;
  localparam logic [N-1:0] Bit41 = 42'd1 << 41;

  logic clk, rst_n, cfg_csn, cfg_sck, cfg_mosi, cfg_miso, cfg_miso_oe;
  logic [N-1:0] bidir_in, bidir_out, bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;
  logic frame_done, frame_err;

  int total = 0;
  int bad = 0;
  int n_done = 0;
  int n_err = 0;

  bidir_pad_ctrl #(.NUM_BIDIR(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_csn    (cfg_csn),
    .cfg_sck    (cfg_sck),
    .cfg_mosi   (cfg_mosi),
    .cfg_miso   (cfg_miso),
    .cfg_miso_oe(cfg_miso_oe),
    .bidir_in   (bidir_in),
    .bidir_out  (bidir_out),
    .bidir_oe   (bidir_oe),
    .bidir_cs   (bidir_cs),
    .bidir_sl   (bidir_sl),
    .bidir_ie   (bidir_ie),
    .bidir_pu   (bidir_pu),
    .bidir_pd   (bidir_pd),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done) n_done <= n_done + 1;
    if (frame_err) n_err <= n_err + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic m);
    cfg_mosi = b;
    wait_clk(4);
    m = cfg_miso;
    cfg_sck = 1'b1;
    wait_clk(4);
    cfg_sck = 1'b0;
  endtask

  // Full frame: returns shifted-out MISO bits, MISO enable mid-frame, and the
  // done/err samples taken after clk edges 2, 3 and 4 following the csn rise.
  task automatic spi_frame(input int nbits, input logic [16:0] data, output logic [16:0] miso_w,
                           output logic oe_mid, output logic [2:0] dseq, output logic [2:0] eseq);
    logic m;
    miso_w = 17'h0;
    cfg_csn = 1'b0;
    wait_clk(4);
    oe_mid = cfg_miso_oe;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_bit(data[i], m);
      miso_w = {miso_w[15:0], m};
    end
    wait_clk(4);
    cfg_csn = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 dseq[2] = frame_done; eseq[2] = frame_err;
    @(posedge clk);
    #1 dseq[1] = frame_done; eseq[1] = frame_err;
    @(posedge clk);
    #1 dseq[0] = frame_done; eseq[0] = frame_err;
    wait_clk(4);
  endtask

  initial begin
    logic [16:0] mw;
    logic oe_mid, b;
    logic [2:0] ds, es;
    int d0, e0;

    rst_n = 1'b0; cfg_csn = 1'b1; cfg_sck = 1'b0; cfg_mosi = 1'b0;
    bidir_in = Bit5;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);

    check("rst_oe", 64'(bidir_oe), 64'(0));
    check("rst_out", 64'(bidir_out), 64'(0));
    check("rst_cs_sl", 64'({bidir_cs, bidir_sl}), 64'(0));
    check("rst_ie", 64'(bidir_ie), 64'(All1));
    check("rst_pu", 64'(bidir_pu), 64'(0));
    check("rst_pd", 64'(bidir_pd), 64'(All1));
    check("rst_miso", 64'({cfg_miso_oe, cfg_miso, frame_done, frame_err}), 64'(0));

    // Write pad 5 with every control set; pd is masked by pu.
    spi_frame(16, 17'h08A7F, mw, oe_mid, ds, es);
    check("wr5_oe_mid", 64'(oe_mid), 64'(1));
    check("wr5_miso", 64'(mw[15:0]), 64'(16'h0000));
    check("wr5_done_seq", 64'(ds), 64'(3'b010));
    check("wr5_err_seq", 64'(es), 64'(3'b000));
    check("wr5_oe", 64'(bidir_oe), 64'(Bit5));
    check("wr5_out_cs_sl", 64'({bidir_out, bidir_cs, bidir_sl}), 64'({Bit5, Bit5, Bit5}));
    check("wr5_ie", 64'(bidir_ie), 64'(All1));
    check("wr5_pu", 64'(bidir_pu), 64'(Bit5));
    check("wr5_pd", 64'(bidir_pd), 64'(All1 & ~Bit5));
    check("miso_oe_idle", 64'(cfg_miso_oe), 64'(0));

    // Read pad 5, then clock the response out with a harmless out-of-range write.
    spi_frame(16, 17'h00A00, mw, oe_mid, ds, es);
    check("rd5_done_seq", 64'(ds), 64'(3'b010));
    check("rd5_miso_empty", 64'(mw[15:0]), 64'(16'h0000));
    spi_frame(16, 17'h0FE00, mw, oe_mid, ds, es);
    check("rd5_resp", 64'(mw[15:0]), 64'({1'b1, 1'b1, 6'd5, 1'b0, 7'h7F}));
    spi_frame(16, 17'h0FE00, mw, oe_mid, ds, es);
    check("rd5_resp_once", 64'(mw[15:0]), 64'(16'h0000));

    // Untouched pad 7 reads back its reset value with bidir_in[7]=0.
    spi_frame(16, 17'h00E00, mw, oe_mid, ds, es);
    spi_frame(16, 17'h0FE00, mw, oe_mid, ds, es);
    check("rd7_resp", 64'(mw[15:0]), 64'(16'h8705));

    // Out-of-range write and read.
    spi_frame(16, 17'h0E47F, mw, oe_mid, ds, es);
    check("wr50_done_seq", 64'(ds), 64'(3'b010));
    check("wr50_no_change", 64'({bidir_oe, bidir_pu}), 64'({Bit5, Bit5}));
    spi_frame(16, 17'h06400, mw, oe_mid, ds, es);
    spi_frame(16, 17'h0FE00, mw, oe_mid, ds, es);
    check("rd50_resp", 64'(mw[15:0]), 64'({2'b00, 6'd50, 8'h00}));

    // Short and long frames are rejected.
    spi_frame(16, 17'h00A00, mw, oe_mid, ds, es);
    spi_frame(15, 17'h0403F, mw, oe_mid, ds, es);
    check("f15_miso", 64'(mw[14:0]), 64'(16'hC57F >> 1));
    check("f15_done_seq", 64'(ds), 64'(3'b000));
    check("f15_err_seq", 64'(es), 64'(3'b010));
    spi_frame(17, 17'h0807F, mw, oe_mid, ds, es);
    check("f17_miso", 64'(mw), 64'(0));
    check("f17_err_seq", 64'(es), 64'(3'b010));
    check("f17_done_seq", 64'(ds), 64'(3'b000));
    check("ferr_cfg_kept", 64'({bidir_oe, bidir_out}), 64'({Bit5, Bit5}));
    spi_frame(16, 17'h0FE00, mw, oe_mid, ds, es);
    check("ferr_no_resp", 64'(mw[15:0]), 64'(16'h0000));

    // csn pulse without sck.
    d0 = n_done; e0 = n_err;
    cfg_csn = 1'b0;
    wait_clk(4);
    cfg_csn = 1'b1;
    wait_clk(8);
    check("empty_pulses", 64'({n_done - d0, n_err - e0}), 64'(0));

    // Reset in the middle of a write to pad 9.
    d0 = n_done; e0 = n_err;
    cfg_csn = 1'b0;
    wait_clk(4);
    for (int i = 15; i >= 8; i--) spi_bit(1'(16'h927F >> i), b);
    rst_n = 1'b0;
    #1;
    check("midrst_oe_pu", 64'({bidir_oe, bidir_pu}), 64'(0));
    check("midrst_pd_ie", 64'({bidir_pd, bidir_ie}), 64'({All1, All1}));
    cfg_csn = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    check("midrst_pulses", 64'({n_done - d0, n_err - e0}), 64'(0));
    check("midrst_miso_oe", 64'(cfg_miso_oe), 64'(0));

    spi_frame(16, 17'h0927F, mw, oe_mid, ds, es);
    check("wr9_done_seq", 64'(ds), 64'(3'b010));
    check("wr9_oe", 64'(bidir_oe), 64'(Bit9));
    check("wr9_pd", 64'(bidir_pd), 64'(All1 & ~Bit9));

    // Highest pad: out, pu, pd set; ie cleared; pd masked by pu.
    spi_frame(16, 17'h0D223, mw, oe_mid, ds, es);
    check("wr41_out", 64'(bidir_out), 64'(Bit9 | Bit41));
    check("wr41_ie", 64'(bidir_ie), 64'(All1 & ~Bit41));
    check("wr41_pu", 64'(bidir_pu), 64'(Bit9 | Bit41));
    check("wr41_pd", 64'(bidir_pd), 64'(All1 & ~Bit9 & ~Bit41));
    check("wr41_oe", 64'(bidir_oe), 64'(Bit9));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
